// File: rtl/event_stretch.sv
// Stretches single-cycle event strobes into fixed-length output windows with a guaranteed
// low gap, queueing events that arrive mid-window. Optional: EVENT_STRETCH_RETRIGGER_EN.
module event_stretch #(
  parameter int unsigned ON_CYCLES  = 20000000,
  parameter int unsigned OFF_CYCLES = 10000000,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned TIMER_W    = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulseIn,
  input  logic             clear,
  output logic             ledOut,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam logic [TIMER_W-1:0] OnLoad  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OffLoad = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PendMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               inc, dec, expired;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    inc     = 1'b0;
    dec     = 1'b0;
    expired = (timer_q == '0);

    unique case (state_q)
      StIdle: begin
        if (pulseIn) begin
          state_d = StOn;
          timer_d = OnLoad;
        end
      end
      StOn: begin
`ifdef EVENT_STRETCH_RETRIGGER_EN
        if (pulseIn) begin
          timer_d = OnLoad;
        end else if (expired) begin
          state_d = StOff;
          timer_d = OffLoad;
        end else begin
          timer_d = timer_q - 1'b1;
        end
`else
        inc = pulseIn;
        if (expired) begin
          state_d = StOff;
          timer_d = OffLoad;
        end else begin
          timer_d = timer_q - 1'b1;
        end
`endif
      end
      StOff: begin
        inc = pulseIn;
        if (expired) begin
          if ((pend_q != '0) || pulseIn) begin
            // Leaving OFF always consumes one event: queued, or the one arriving now.
            state_d = StOn;
            timer_d = OnLoad;
            dec     = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase

    if (inc && !dec) begin
      if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - 1'b1;
    end

    if (clear) begin
      state_d = StIdle;
      timer_d = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end

    led_d  = (state_d == StOn);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign ledOut   = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_event_stretch.sv
// Directed self-checking bench for event_stretch (ON=4, OFF=2, CNT_W=2).
module tb_event_stretch;

  localparam int unsigned CntW = 2;

  logic            clk;
  logic            rst_n;
  logic            pulseIn;
  logic            clear;
  logic            ledOut;
  logic            busy;
  logic [CntW-1:0] pending;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  logic [63:0]     led_v, busy_v, ovf_v;
  logic [CntW-1:0] pend_a [64];
  logic [CntW-1:0] pend_or;
  int              cyc;

  event_stretch #(
    .ON_CYCLES (4),
    .OFF_CYCLES(2),
    .CNT_W     (CntW),
    .TIMER_W   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulseIn (pulseIn),
    .clear   (clear),
    .ledOut  (ledOut),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_log();
    led_v   = '0;
    busy_v  = '0;
    ovf_v   = '0;
    pend_or = '0;
    cyc     = 0;
  endtask

  // Cycle n spans posedge n to posedge n+1; outputs are sampled on the falling edge.
  task automatic do_cycle(input logic p, input logic c);
    pulseIn = p;
    clear   = c;
    @(negedge clk);
    led_v[cyc]  = ledOut;
    busy_v[cyc] = busy;
    ovf_v[cyc]  = overflow;
    pend_a[cyc] = pending;
    pend_or     = pend_or | pending;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pulses(input logic [63:0] pmask, input int n);
    start_log();
    for (int i = 0; i < n; i++) do_cycle(pmask[i], 1'b0);
  endtask

  task automatic do_reset();
    pulseIn = 1'b0;
    clear   = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rises;
    rst_n   = 1'b1;
    pulseIn = 1'b0;
    clear   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_led", ledOut, 0);
    check("reset_busy", busy, 0);
    check("reset_pending", pending, 0);
    check("reset_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single pulse
    run_pulses(64'h1, 10);
    check("t1_led", led_v[9:0], 10'h01E);
    check("t1_busy", busy_v[9:0], 10'h07E);
    check("t1_pending", pend_or, 0);

    // 4: second pulse on last OFF cycle, no extra gap
    do_reset();
    run_pulses(64'h41, 16);
    check("t4_led", led_v[15:0], 16'h079E);
    check("t4_busy", busy_v[15:0], 16'h1FFE);
    check("t4_pending", pend_or, 0);

`ifdef EVENT_STRETCH_RETRIGGER_EN
    do_reset();
    run_pulses(64'h9, 12);
    check("rt_led", led_v[11:0], 12'h0FE);
    check("rt_busy", busy_v[11:0], 12'h3FE);
    check("rt_pending", pend_or, 0);
`else
    // 2: three queued events
    do_reset();
    run_pulses(64'h7, 24);
    check("t2_led", led_v[23:0], 24'h01E79E);
    check("t2_busy", busy_v[23:0], 24'h07FFFE);
    check("t2_pend_c2", pend_a[2], 1);
    check("t2_pend_c3", pend_a[3], 2);
    check("t2_pend_c7", pend_a[7], 1);
    check("t2_pend_c13", pend_a[13], 0);

    // 3: saturation and sticky overflow
    do_reset();
    run_pulses(64'h3F, 30);
    check("t3_led", led_v[29:0], 30'h0079E79E);
    check("t3_ovf_c4", ovf_v[4], 0);
    check("t3_ovf_c5", ovf_v[5], 1);
    check("t3_pend_c5", pend_a[5], 3);
    check("t3_busy_c29", busy_v[29], 0);
    check("t3_ovf_c29", ovf_v[29], 1);
    rises = 0;
    for (int i = 1; i < 30; i++) if (led_v[i] && !led_v[i-1]) rises++;
    check("t3_windows", rises, 4);

    // 5: asynchronous reset mid-window with pending=2
    do_reset();
    run_pulses(64'h7, 3);
    pulseIn = 1'b0;
    @(negedge clk);
    check("t5_led_pre", ledOut, 1);
    check("t5_pend_pre", pending, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_led_async", ledOut, 0);
    check("t5_busy_async", busy, 0);
    check("t5_pend_async", pending, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_pulses(64'h1, 8);
    check("t5_led_after", led_v[7:0], 8'h1E);
    check("t5_busy_after", busy_v[7:0], 8'h7E);

    // 6: clear with simultaneous pulse during ON with overflow set
    do_reset();
    start_log();
    for (int i = 0; i < 13; i++) do_cycle((i < 5) || (i == 7), i == 7);
    check("t6_led_c7", led_v[7], 1);
    check("t6_ovf_c7", ovf_v[7], 1);
    check("t6_led_c8", led_v[8], 0);
    check("t6_busy_c8", busy_v[8], 0);
    check("t6_pend_c8", pend_a[8], 0);
    check("t6_ovf_c8", ovf_v[8], 0);
    check("t6_idle_after", {led_v[12:8], busy_v[12:8]}, 10'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
